clock_div_4: RTL and testbench
==============================

Name: clock_div_4

Overview:
- Synchronous divide-by-4 clock generator built from cascaded divide-by-2 (f/2) toggle stages.
- Produces a 50 % duty-cycle output at clk/4, fully registered in the clk domain. No ripple clocking.
- Sits at the clock-generation edge of a design and feeds slow-clock or strobe consumers.
- Parameterised stage count; the default of 2 gives /4.

Parameters:
- STAGES, 2, number of cascaded f/2 stages; output frequency = clk / 2^STAGES. Legal range is 1..16; elaborate-time error outside it.

Ports:
- clk  input  1  reference clock; all state updates on its rising edge.
- rst  input  1  asynchronous, active-low reset. 0 = reset asserted; 1 = run.
- out_clk2  output  1  divided clock, clk/2^STAGES (clk/4 at default), 50 % duty.

Behaviour:
- State: STAGES toggle flops q[0..STAGES-1], each an f/2 stage.
- Reset: rst=0 immediately forces all q to 0, independent of clk. out_clk2=0 while rst=0.
- Stage rules, on each clk rising edge with rst=1:
  - q[0] toggles every cycle.
  - q[k] toggles when q[0..k-1] are all 1. This is a synchronous enable chain; q[k-1] is never used as a clock.
  - The result is equivalent to a binary up-counter with q[0] as LSB.
- Output: out_clk2 = q[STAGES-1], driven directly from a flop with no combinational logic on the output path. Glitch-free.
- Timing at default STAGES=2, counting clk rising edges after rst deasserts (edge 1 is the first edge with rst=1):
  - q0 sequence: 1,0,1,0,...
  - out_clk2 sequence: 0,1,1,0,0,1,1,...
  - out_clk2 rises on edge 2, falls on edge 4, rises on edge 6. Period 4 clk cycles: high 2 cycles, low 2 cycles.
- Wrap-around: all-ones state rolls to all-zeros. out_clk2 falls on that edge. No terminal state or stall.
- Reset deassertion:
  - rst rising between clk edges has no effect until the next clk rising edge.
  - Deassertion coincident with a clk edge: that edge does not count. Counting starts on the following edge.
  - No internal reset synchroniser; rst deassertion is synchronised upstream.
- Reset mid-operation: asserting rst at any phase, including while out_clk2=1, drops out_clk2 to 0 asynchronously. The next deassertion restarts the phase sequence from edge 1.
- No X on out_clk2 after the first rst assertion.

Decomposition:
- Shared package clk_div_pkg:
  - localparam MAX_STAGES = 16.
  - Function div_ratio(STAGES) returning 2^STAGES, for bench checking.
- One natural sub-module, div2_stage:
  - Ports: clk, rst, en, q.
  - rst is asynchronous active-low, clears q to 0.
  - q toggles on clk rising edge when en=1.
- clock_div_4 instantiates STAGES copies of div2_stage in a generate loop:
  - en[0] = 1.
  - en[k] = en[k-1] & q[k-1].

Test Plan:
- Reset hold: clk period 10 ns, rst=0 for 30 ns -> out_clk2=0 and q=00 throughout, including across clk edges.
- Division ratio: release rst, run 100 ns -> out_clk2 sequence per edge is 0,1,1,0,0,1,1,0,0,1. Period is 40 ns, high time 20 ns, low time 20 ns.
- Phase after release: rst deasserts at t=12 ns with clk edges at 5,15,25,... -> out_clk2 rises at 25 ns and falls at 45 ns.
- Async reset mid-high: assert rst at t=27 ns while out_clk2=1 -> out_clk2=0 at 27 ns without waiting for a clk edge. After release, the first rise is on the 2nd following edge.
- Parameter sweep: STAGES=1 gives a period of 2 clk cycles; STAGES=3 gives a period of 8 clk cycles (high 4, low 4). Wrap-around from 111 to 000 drops the output.
- Glitch check: sample out_clk2 on both clk edges for 1000 cycles -> changes only on clk rising edges (or on reset assertion). Duty count is exactly 50 %.

Source files
------------

// File: rtl/clk_div_pkg.sv
// Shared constants and helpers for the cascaded divide-by-2 clock generator.
// The clock-divider RTL and its testbench both import this package.
package clk_div_pkg;

    localparam int MAX_STAGES = 16;

    // Division ratio produced by a chain of 'stages' f/2 stages.
    function automatic int unsigned div_ratio(input int unsigned stages);
        return 32'd1 << stages;
    endfunction

endpackage : clk_div_pkg

// File: rtl/div2_stage.sv
// One f/2 stage: a toggle flop with a synchronous enable.
// It is cleared asynchronously by the active-low reset.
module div2_stage (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic q
);

    logic q_q;
    logic q_d;

    always_comb begin
        q_d = q_q ^ en;
    end

    // NOTE: the reset is asynchronous and active-low, so it sits in the sensitivity
    // list; sequential state is written with <= only.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q_q <= 1'b0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule : div2_stage

// File: rtl/clock_div_4.sv
// Fully synchronous clk / 2^STAGES generator (default /4) with a 50 % duty cycle.
// Every stage runs on clk, so there is no ripple clocking.
module clock_div_4
    import clk_div_pkg::*;
#(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    output logic out_clk2
);

    if (STAGES < 1 || STAGES > MAX_STAGES) begin : g_bad_stages
        $error("clock_div_4: STAGES=%0d outside legal range 1..%0d", STAGES, MAX_STAGES);
    end

    logic [STAGES-1:0] en;
    logic [STAGES-1:0] stage_q;

    // A stage toggles only when all lower stages are 1 (a carry chain, not a ripple clock).
    assign en[0] = 1'b1;
    for (genvar k = 1; k < STAGES; k++) begin : g_en
        assign en[k] = en[k-1] & stage_q[k-1];
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        div2_stage u_stage (
            .clk (clk),
            .rst (rst),
            .en  (en[k]),
            .q   (stage_q[k])
        );
    end

    assign out_clk2 = stage_q[STAGES-1];

endmodule : clock_div_4

// File: tb/tb_clock_div_4.sv
// Testbench for clock_div_4. It drives instances with STAGES = 1, 2 and 3 from a
// shared clock and a shared reset.
module tb_clock_div_4;
    import clk_div_pkg::*;

    localparam int HALF = 5;
    localparam int PER  = 2 * HALF;

    logic clk;
    logic rst;
    logic o1, o2, o3;
    logic [2:0] outs;

    assign outs = {o3, o2, o1};

    clock_div_4 #(.STAGES(1)) u_dut1 (.clk(clk), .rst(rst), .out_clk2(o1));
    clock_div_4 #(.STAGES(2)) u_dut2 (.clk(clk), .rst(rst), .out_clk2(o2));
    clock_div_4 #(.STAGES(3)) u_dut3 (.clk(clk), .rst(rst), .out_clk2(o3));

    initial begin
        clk = 1'b0;
        forever #HALF clk = ~clk;
    end

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard: an expectation is queued when the stimulus is driven and popped after the edge.
    logic [2:0] exp_q[$];

    task automatic step(input logic r, input logic [2:0] e, input string name);
        logic [2:0] want;
        @(negedge clk);
        #2;
        rst = r;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        want = exp_q.pop_front();
        check(name, 64'(outs), 64'(want));
    endtask

    // Change log for the /4 output, and the last two rise times of each output.
    bit  log_en = 1'b0;
    time chg_q[$];
    time rise_prev[3];
    time rise_last[3];

    always @(o2) if (log_en) chg_q.push_back($time);
    always @(posedge o1) begin rise_prev[0] = rise_last[0]; rise_last[0] = $time; end
    always @(posedge o2) begin rise_prev[1] = rise_last[1]; rise_last[1] = $time; end
    always @(posedge o3) begin rise_prev[2] = rise_last[2]; rise_last[2] = $time; end

    typedef struct packed {
        logic       rst_v;
        logic [2:0] exp;
    } vec_t;

    vec_t vecs[10];

    initial begin
        time t_rel;
        time t_assert;
        int  glitches;
        int  model_bad;
        int  hi[3];
        int  n;
        logic [2:0] a, b, c;

        // Outputs after release edges 1..10 are {o3,o2,o1} = edge count mod 8.
        vecs[0] = '{1'b1, 3'b001};
        vecs[1] = '{1'b1, 3'b010};
        vecs[2] = '{1'b1, 3'b011};
        vecs[3] = '{1'b1, 3'b100};
        vecs[4] = '{1'b1, 3'b101};
        vecs[5] = '{1'b1, 3'b110};
        vecs[6] = '{1'b1, 3'b111};
        vecs[7] = '{1'b1, 3'b000};
        vecs[8] = '{1'b1, 3'b001};
        vecs[9] = '{1'b1, 3'b010};

        rst = 1'b1;
        #1 rst = 1'b0;
        #1 check("reset_immediate", 64'(outs), 64'd0);

        // Reset held across three clock edges.
        for (int i = 0; i < 3; i++) step(1'b0, 3'b000, $sformatf("reset_hold_%0d", i));

        // Release between edges, then run the table.
        log_en = 1'b1;
        t_rel  = 0;
        for (int i = 0; i < 10; i++) begin
            if (i == 0) t_rel = ($time / PER) * PER + PER + 2;
            step(vecs[i].rst_v, vecs[i].exp, $sformatf("vec_%0d", i));
        end

        check("chg_count", 64'(chg_q.size()), 64'd5);
        if (chg_q.size() >= 3) begin
            check("first_rise_time", 64'(chg_q[0] - t_rel), 64'(13));
            check("first_fall_time", 64'(chg_q[1] - t_rel), 64'(33));
            check("period_div4", 64'(chg_q[2] - chg_q[0]), 64'(PER * div_ratio(2)));
        end

        // Asynchronous reset while the /4 output is high.
        #1;
        t_assert = $time;
        rst = 1'b0;
        #1;
        check("async_clr_out", 64'(outs), 64'd0);
        check("async_clr_time", 64'(chg_q[chg_q.size()-1]), 64'(t_assert));
        step(1'b0, 3'b000, "mid_reset_hold");
        step(1'b1, 3'b001, "restart_edge1");
        step(1'b1, 3'b010, "restart_edge2_rise");

        // Long run: outputs must be stable between rising edges and follow the count.
        glitches  = 0;
        model_bad = 0;
        hi        = '{0, 0, 0};
        n         = 2;
        for (int i = 0; i < 1000; i++) begin
            @(posedge clk);
            #1 a = outs;
            n = n + 1;
            exp_q.push_back(3'(n));
            @(negedge clk);
            b = outs;
            #(HALF - 1);
            c = outs;
            if (a !== exp_q.pop_front()) model_bad++;
            if (a !== b || b !== c) glitches++;
            for (int k = 0; k < 3; k++) if (a[k]) hi[k]++;
        end
        check("long_run_sequence", 64'(model_bad), 64'd0);
        check("glitch_count", 64'(glitches), 64'd0);
        for (int k = 0; k < 3; k++) begin
            check($sformatf("duty_high_s%0d", k + 1), 64'(hi[k]), 64'(1000 / 2));
            check($sformatf("period_s%0d", k + 1), 64'(rise_last[k] - rise_prev[k]),
                  64'(PER * div_ratio(k + 1)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

endmodule : tb_clock_div_4
